md_unit: RTL and testbench

//  Multiply/divide unit of the Execute stage, fed by the D/E pipeline register (RD1_E/RD2_E, decoded IR_E).

---
 rtl/md_unit.sv | 138 +++++++++++++
 tb/tb_md_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Brief    : Execute-stage multiply/divide unit holding architectural HI/LO.
//            Multi-cycle MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO.
// Revision : 1.0 - initial release
// ============================================================================
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_en,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rd
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] C_MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] C_DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] C_CNT_ONE   = CW'(1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   hi_nx_q, hi_nx_d;
    logic [31:0]   lo_nx_q, lo_nx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div_signed;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_divisor;
    logic [31:0] w_uquot;
    logic [31:0] w_urem;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Low 64 bits of a sign-extended 64x64 product equal the signed 32x32 product.
    assign w_prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    assign w_prod_u = {32'd0, src_a} * {32'd0, src_b};

    // Signed division done on magnitudes so 0x80000000 / -1 wraps cleanly
    // instead of overflowing; a zero divisor is replaced to keep the divider defined.
    assign w_div_signed = (md_op == OP_DIV);
    assign w_mag_a      = (w_div_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
    assign w_mag_b      = (w_div_signed && src_b[31]) ? (32'd0 - src_b) : src_b;
    assign w_divisor    = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
    assign w_uquot      = w_mag_a / w_divisor;
    assign w_urem       = w_mag_a % w_divisor;
    assign w_quot       = (w_div_signed && (src_a[31] ^ src_b[31])) ? (32'd0 - w_uquot) : w_uquot;
    assign w_rem        = (w_div_signed && src_a[31]) ? (32'd0 - w_urem) : w_urem;

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_nx_d = hi_nx_q;
        lo_nx_d = lo_nx_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;

        if (cnt_q != '0) begin
            cnt_d = cnt_q - C_CNT_ONE;
            if (cnt_q == C_CNT_ONE && wr_q) begin
                hi_d = hi_nx_q;
                lo_d = lo_nx_q;
            end
        end else if (md_en) begin
            case (md_op)
                OP_MULT: begin
                    hi_nx_d = w_prod_s[63:32];
                    lo_nx_d = w_prod_s[31:0];
                    cnt_d   = C_MULT_LOAD;
                    wr_d    = 1'b1;
                end
                OP_MULTU: begin
                    hi_nx_d = w_prod_u[63:32];
                    lo_nx_d = w_prod_u[31:0];
                    cnt_d   = C_MULT_LOAD;
                    wr_d    = 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    hi_nx_d = w_rem;
                    lo_nx_d = w_quot;
                    cnt_d   = C_DIV_LOAD;
                    // Divide by zero still occupies the unit but leaves HI/LO untouched.
                    wr_d    = (src_b != 32'd0);
                end
                OP_MTHI: hi_d = src_a;
                OP_MTLO: lo_d = src_a;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q    <= '0;
            lo_q    <= '0;
            hi_nx_q <= '0;
            lo_nx_q <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_nx_q <= hi_nx_d;
            lo_nx_q <= lo_nx_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
        end
    end

    assign busy  = (cnt_q != '0);
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign md_rd = rd_sel ? hi_q : lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_unit
// Brief    : Directed scoreboard bench for md_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        md_en;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        rd_sel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_rd;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .md_en  (md_en),
        .md_op  (md_op),
        .src_a  (src_a),
        .src_b  (src_b),
        .rd_sel (rd_sel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .md_rd  (md_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one op for exactly one edge; returns at the negedge after that edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        md_en = 1'b1;
        md_op = op;
        src_a = a;
        src_b = b;
        @(negedge clk);
        md_en = 1'b0;
        md_op = 3'd0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic sb_check(input string tag);
        logic [63:0] exp;
        checks++;
        assert (sb_q.size() != 0) else begin
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb_q.size() != 0) begin
            exp = sb_q.pop_front();
            check({tag, "_hi"}, hi, exp[63:32]);
            check({tag, "_lo"}, lo, exp[31:0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset  = 1'b1;
        md_en  = 1'b0;
        md_op  = 3'd0;
        src_a  = '0;
        src_b  = '0;
        rd_sel = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_md_rd", md_rd, 32'd0);

        // MULT / MULTU
        sb_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFA});
        issue(3'd1, 32'hFFFFFFFE, 32'd3);
        wait_done(n);
        check("mult_cycles", n, 32'd5);
        sb_check("mult");

        sb_q.push_back({32'h00000002, 32'hFFFFFFFA});
        issue(3'd2, 32'hFFFFFFFE, 32'd3);
        wait_done(n);
        check("multu_cycles", n, 32'd5);
        sb_check("multu");

        // DIV / DIVU, including the signed overflow corner
        sb_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        wait_done(n);
        check("div_cycles", n, 32'd10);
        sb_check("div");

        sb_q.push_back({32'd1, 32'd3});
        issue(3'd4, 32'd7, 32'd2);
        wait_done(n);
        check("divu_cycles", n, 32'd10);
        sb_check("divu");

        sb_q.push_back({32'd0, 32'h80000000});
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_done(n);
        sb_check("div_ovf");

        // MTHI then MTLO on consecutive cycles
        @(negedge clk);
        md_en = 1'b1;
        md_op = 3'd5;
        src_a = 32'h1234;
        @(negedge clk);
        check("mthi_hi", hi, 32'h1234);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        md_op = 3'd6;
        src_a = 32'h5678;
        @(negedge clk);
        md_en = 1'b0;
        md_op = 3'd0;
        check("mtlo_lo", lo, 32'h5678);
        check("mtlo_hi", hi, 32'h1234);
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        rd_sel = 1'b1;
        #1 check("mfhi", md_rd, 32'h1234);
        rd_sel = 1'b0;
        #1 check("mflo", md_rd, 32'h5678);

        // Divide by zero preserves HI/LO; MULT while busy is ignored
        issue(3'd5, 32'hAA, 32'd0);
        issue(3'd6, 32'hBB, 32'd0);
        sb_q.push_back({32'hAA, 32'hBB});
        issue(3'd3, 32'd5, 32'd0);
        md_en = 1'b1;
        md_op = 3'd1;
        src_a = 32'd2;
        src_b = 32'd2;
        @(negedge clk);
        md_en = 1'b0;
        md_op = 3'd0;
        wait_done(n);
        check("div0_cycles", n + 1, 32'd10);
        sb_check("div0");
        @(negedge clk);
        check("no_restart_busy", {31'd0, busy}, 32'd0);
        check("no_restart_lo", lo, 32'hBB);

        // Reset on cycle 3 of a DIV discards the pending result
        issue(3'd5, 32'h11, 32'd0);
        issue(3'd3, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        repeat (12) @(negedge clk);
        check("midrst_late_hi", hi, 32'd0);
        check("midrst_late_lo", lo, 32'd0);
        check("midrst_late_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
